// File: rtl/divider_hd_if.sv
// Digit-serial stream bundle for divider_hd: dividend and divisor digit
// streams in, quotient digit stream out, each with a valid/ready handshake.
interface divider_hd_if;
  logic [1:0] x_value;
  logic [1:0] d_value;
  logic [1:0] q_value;
  logic       data_x_vld;
  logic       data_x_rdy;
  logic       data_d_vld;
  logic       data_d_rdy;
  logic       data_out_vld;
  logic       data_out_rdy;

  // Producer/consumer side (drives operands, accepts quotient)
  modport master (
    output x_value, d_value, data_x_vld, data_d_vld, data_out_rdy,
    input  q_value, data_x_rdy, data_d_rdy, data_out_vld
  );

  // Divider side
  modport slave (
    input  x_value, d_value, data_x_vld, data_d_vld, data_out_rdy,
    output q_value, data_x_rdy, data_d_rdy, data_out_vld
  );
endinterface

// File: rtl/divider_hd.sv
// Radix-2 online (MSD-first) signed-digit divider. Consumes one dividend and
// one divisor digit per step, emits one quotient digit per step after DELTA
// steps of online delay. One division of N digits per reset.
// Residual, divisor and quotient are exact integers scaled by 2^(N+DELTA).
module divider_hd #(
  parameter int N     = 101,
  parameter int DELTA = 4
) (
  input logic         clk,
  input logic         asyn_reset,
  divider_hd_if.slave bus
);

  localparam int FW = N + DELTA;              // fractional bits of the scaling
  localparam int W  = FW + 3;                 // sign + two integer bits
  localparam int CW = $clog2(FW + DELTA) + 1; // step counter / shift width

  localparam logic signed [W-1:0] ONE      = W'(1);
  localparam logic signed [W-1:0] HALF     = ONE <<< (FW - 1);
  localparam logic signed [W-1:0] NEG_HALF = -HALF;
  localparam logic signed [W-1:0] A_UNIT   = ONE <<< N;      // 2^-DELTA

  localparam logic [CW-1:0] LAST_IN   = CW'(N - 1);
  localparam logic [CW-1:0] STEPS     = CW'(FW);
  localparam logic [CW-1:0] DLY       = CW'(DELTA);
  localparam logic [CW-1:0] D_SH_BASE = CW'(FW - 1);
  localparam logic [CW-1:0] Q_SH_BASE = CW'(FW + DELTA - 1);

  typedef enum logic [1:0] {
    RUN_IN = 2'd0,
    FLUSH  = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         step_q, step_d;   // steps fired so far; j = step - DELTA
  logic signed [W-1:0]   w_q, w_d;
  logic signed [W-1:0]   dacc_q, dacc_d;
  logic signed [W-1:0]   qacc_q, qacc_d;
  logic [1:0]            qv_q, qv_d;
  logic                  ovld_q, ovld_d;

  logic                  out_free;
  logic                  run_ok;
  logic                  pair_fire;
  logic                  step_fire;

  logic signed [1:0]     a_dig, b_dig, q_dig;
  logic [CW-1:0]         d_shamt, q_shamt;
  logic signed [W-1:0]   d_new, v, w_new, q_new;

  // Digit code 01 = +1, 10 = -1, anything else = 0
  function automatic logic signed [1:0] dig_decode(input logic [1:0] c);
    case (c)
      2'b01:   return 2'sd1;
      2'b10:   return -2'sd1;
      default: return 2'sd0;
    endcase
  endfunction

  function automatic logic [1:0] dig_encode(input logic signed [1:0] d);
    if (d > 2'sd0)      return 2'b01;
    else if (d < 2'sd0) return 2'b10;
    else                return 2'b00;
  endfunction

  // Quotient digit selection on the full-precision residual
  function automatic logic signed [1:0] select_q(input logic signed [W-1:0] val);
    if (val >= HALF)         return 2'sd1;
    else if (val < NEG_HALF) return -2'sd1;
    else                     return 2'sd0;
  endfunction

  // Multiply by a signed digit (-1, 0, +1)
  function automatic logic signed [W-1:0] scale_by(input logic signed [1:0] s,
                                                   input logic signed [W-1:0] m);
    if (s > 2'sd0)      return m;
    else if (s < 2'sd0) return -m;
    else                return '0;
  endfunction

  // Handshake qualification: a step needs room at the output
  always_comb begin
    out_free  = !ovld_q || bus.data_out_rdy;
    run_ok    = (state_q == RUN_IN) && out_free && asyn_reset;
    pair_fire = run_ok && bus.data_x_vld && bus.data_d_vld;
    step_fire = pair_fire || ((state_q == FLUSH) && out_free && (step_q != STEPS));
  end

  // One online-division step: residual, divisor and quotient updates
  always_comb begin
    a_dig   = (state_q == RUN_IN) ? dig_decode(bus.x_value) : 2'sd0;
    b_dig   = (state_q == RUN_IN) ? dig_decode(bus.d_value) : 2'sd0;
    d_shamt = D_SH_BASE - step_q;
    q_shamt = Q_SH_BASE - step_q;
    d_new   = dacc_q + scale_by(b_dig, ONE <<< d_shamt);
    v       = (w_q <<< 1) + scale_by(a_dig, A_UNIT) - (scale_by(b_dig, qacc_q) >>> DELTA);
    q_dig   = (step_q < DLY) ? 2'sd0 : select_q(v);
    w_new   = v - scale_by(q_dig, d_new);
    q_new   = qacc_q + scale_by(q_dig, ONE <<< q_shamt);
  end

  // Next-state and register-update decisions
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    w_d     = w_q;
    dacc_d  = dacc_q;
    qacc_d  = qacc_q;
    qv_d    = qv_q;
    ovld_d  = ovld_q;

    if (step_fire) begin
      step_d = step_q + 1'b1;
      w_d    = w_new;
      dacc_d = d_new;
      qacc_d = q_new;
      if (step_q >= DLY) begin
        qv_d   = dig_encode(q_dig);
        ovld_d = 1'b1;
      end
    end else if (ovld_q && bus.data_out_rdy) begin
      ovld_d = 1'b0;
    end

    case (state_q)
      RUN_IN: if (pair_fire && (step_q == LAST_IN)) state_d = FLUSH;
      FLUSH:  if ((step_q == STEPS) && ovld_q && bus.data_out_rdy) state_d = DONE;
      DONE:   state_d = DONE;
      default: state_d = RUN_IN;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!asyn_reset) begin
      state_q <= RUN_IN;
      step_q  <= '0;
      w_q     <= '0;
      dacc_q  <= '0;
      qacc_q  <= '0;
      qv_q    <= 2'b00;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      w_q     <= w_d;
      dacc_q  <= dacc_d;
      qacc_q  <= qacc_d;
      qv_q    <= qv_d;
      ovld_q  <= ovld_d;
    end
  end

  assign bus.q_value      = qv_q;
  assign bus.data_out_vld = ovld_q;
  assign bus.data_x_rdy   = run_ok && bus.data_d_vld;
  assign bus.data_d_rdy   = run_ok && bus.data_x_vld;

endmodule

// File: tb/tb_divider_hd.sv
// Testbench for divider_hd: table of operand pairs with hand-computed quotient
// digit patterns and quotient sums, optional output/input stalls, plus
// hand-written reset sequences (power-up and mid-division).
module tb_divider_hd;
  localparam int N     = 101;
  localparam int DELTA = 4;

  logic clk = 1'b0;
  logic asyn_reset = 1'b0;
  always #5 clk = ~clk;

  divider_hd_if bus ();

  divider_hd #(.N(N), .DELTA(DELTA)) dut (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .bus        (bus)
  );

  // Operand digits 1..8 packed MSD-first (digit 1 in [15:14]); later digits 0.
  // pat selects the hand-derived quotient digit sequence.
  typedef struct {
    logic [15:0]         x_lead;
    logic [15:0]         d_lead;
    int                  pat;
    logic signed [127:0] exp_q;      // sum q_k * 2^(N-k)
    int                  ostall_at;  // digits accepted when out_rdy drops (-1 none)
    int                  ostall_len;
    int                  xgap_at;    // pairs accepted when x_vld drops (-1 none)
    int                  xgap_len;
  } vec_t;

  vec_t vecs[5];
  int checks = 0;
  int errors = 0;

  int ndig, pairs, bad_code, pat_err, stall_bad;
  int first_pair, fifth_pair, first_out, last_out;
  logic signed [127:0] qsum;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] lead_dig(input logic [15:0] lead, input int k);
    if (k < 1 || k > 8) return 2'b00;
    return lead[(17 - 2*k) -: 2];
  endfunction

  function automatic int dec(input logic [1:0] c);
    if (c == 2'b01) return 1;
    if (c == 2'b10) return -1;
    return 0;
  endfunction

  // Quotient digits derived by hand from the recurrence
  function automatic int exp_digit(input int pat, input int k);
    case (pat)
      0:       return (k == 2) ? 1 : 0;                      // 1/8 / 1/2 = 1/4
      2:       return (k >= 3 && (k % 2) == 1) ? -1 : 0;     // -1/8 / 3/4 = -1/6
      default: return 0;                                     // X = 0
    endcase
  endfunction

  task automatic run_div(input vec_t v, input bit do_reset, input int max_cyc);
    int cyc, ocnt, xcnt, tail;
    bit stall_o, gap_x, pfire, ofire;
    logic [1:0] held, qd;
    logic signed [127:0] one;
    one = 128'sd1;
    if (do_reset) begin
      @(negedge clk);
      asyn_reset = 1'b0;
      bus.data_x_vld = 1'b0;
      bus.data_d_vld = 1'b0;
      bus.data_out_rdy = 1'b1;
      @(negedge clk);
      asyn_reset = 1'b1;
    end
    ndig = 0; pairs = 0; bad_code = 0; pat_err = 0; stall_bad = 0;
    first_pair = -1; fifth_pair = -1; first_out = -1; last_out = -1;
    qsum = '0; cyc = 0; ocnt = 0; xcnt = 0; tail = 0; held = 2'b00;
    while (cyc < max_cyc) begin
      if (ndig >= N) begin
        if (tail == 5) break;
        tail++;
      end
      @(negedge clk);
      stall_o = (v.ostall_at >= 0) && (ndig == v.ostall_at) && bus.data_out_vld && (ocnt < v.ostall_len);
      gap_x   = (v.xgap_at >= 0) && (pairs == v.xgap_at) && (xcnt < v.xgap_len);
      bus.data_out_rdy = !stall_o;
      bus.data_x_vld   = !gap_x;
      bus.data_d_vld   = 1'b1;
      bus.x_value      = lead_dig(v.x_lead, pairs + 1);
      bus.d_value      = lead_dig(v.d_lead, pairs + 1);
      #1;
      if (stall_o) begin
        if (ocnt == 0) held = bus.q_value;
        else if (bus.q_value !== held) stall_bad++;
        if (bus.data_x_rdy !== 1'b0 || bus.data_d_rdy !== 1'b0) stall_bad++;
        ocnt++;
      end
      if (gap_x) begin
        if (bus.data_d_rdy !== 1'b0) stall_bad++;
        xcnt++;
      end
      pfire = bus.data_x_vld && bus.data_x_rdy && bus.data_d_vld && bus.data_d_rdy;
      ofire = bus.data_out_vld && bus.data_out_rdy;
      qd    = bus.q_value;
      @(posedge clk);
      cyc++;
      if (pfire) begin
        pairs++;
        if (pairs == 1) first_pair = cyc;
        if (pairs == 5) fifth_pair = cyc;
      end
      if (ofire) begin
        ndig++;
        if (ndig == 1) first_out = cyc;
        last_out = cyc;
        if (qd == 2'b11) bad_code++;
        if (ndig <= N) begin
          if (dec(qd) != exp_digit(v.pat, ndig)) pat_err++;
          if (dec(qd) == 1)  qsum = qsum + (one <<< (N - ndig));
          if (dec(qd) == -1) qsum = qsum - (one <<< (N - ndig));
        end
      end
    end
  endtask

  task automatic post_checks(input vec_t v);
    check("digit_count", ndig, N);
    check("pairs_consumed", pairs, N);
    check("quotient_sum", qsum, v.exp_q);
    check("digit_sequence_errors", pat_err, 0);
    check("code11_seen", bad_code, 0);
    check("first_out_latency", first_out, fifth_pair + 1);
    check("run_length", last_out - first_pair, N + DELTA + v.ostall_len + v.xgap_len);
    check("stall_behaviour_errors", stall_bad, 0);
    @(negedge clk);
    bus.data_x_vld = 1'b1;
    bus.data_d_vld = 1'b1;
    bus.data_out_rdy = 1'b1;
    #1;
    check("done_rdy_vld", {bus.data_x_rdy, bus.data_d_rdy, bus.data_out_vld}, 3'b000);
  endtask

  initial begin
    logic [127:0] third;
    third = ((128'd1 << 100) - 128'd1) / 128'd3;

    vecs[0] = '{16'h0400, 16'h4000, 0, 128'sd1 <<< 99, -1, 0, -1, 0};
    vecs[1] = '{16'h0000, 16'h5000, 1, 128'sd0,        -1, 0, -1, 0};
    vecs[2] = '{16'h0800, 16'h5000, 2, -$signed(third), -1, 0, -1, 0};
    vecs[3] = '{16'h0400, 16'h4000, 0, 128'sd1 <<< 99, 20, 5, -1, 0};
    vecs[4] = '{16'h0800, 16'h5000, 2, -$signed(third), -1, 0, 10, 3};

    // Power-up reset: outputs idle, ready held low while in reset
    bus.x_value = 2'b00;
    bus.d_value = 2'b00;
    bus.data_x_vld = 1'b1;
    bus.data_d_vld = 1'b1;
    bus.data_out_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_rdy", {bus.data_x_rdy, bus.data_d_rdy}, 2'b00);
    check("reset_out", {bus.data_out_vld, bus.q_value}, 3'b000);

    for (int i = 0; i < 5; i++) begin
      run_div(vecs[i], 1'b1, 400);
      post_checks(vecs[i]);
    end

    // Reset mid-division, then a fresh operand pair without another reset
    run_div(vecs[2], 1'b1, 30);
    @(negedge clk);
    asyn_reset = 1'b0;
    bus.data_x_vld = 1'b1;
    bus.data_d_vld = 1'b1;
    bus.data_out_rdy = 1'b1;
    #1;
    check("midrst_rdy", {bus.data_x_rdy, bus.data_d_rdy}, 2'b00);
    @(negedge clk);
    asyn_reset = 1'b1;
    bus.data_x_vld = 1'b0;
    bus.data_d_vld = 1'b0;
    #1;
    check("midrst_out", {bus.data_out_vld, bus.q_value}, 3'b000);
    run_div(vecs[0], 1'b0, 400);
    post_checks(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
